amplifier: RTL and testbench



---
 rtl/amplifier_pkg.sv | 21 ++
 rtl/amplifier_if.sv | 22 ++
 rtl/amp_mult.sv | 13 +
 rtl/amplifier.sv | 76 +++++++
 tb/tb_amplifier.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/amplifier_pkg.sv
// rtl/amplifier_pkg.sv - width constants and datapath types for the programmable-gain multiplier
package amplifier_pkg;

    localparam int WR_DATA_WIDTH = 16;
    localparam int SCALER_WIDTH  = 16;
    localparam int ID_WIDTH      = 8;
    localparam int BASE_WIDTH    = 8;
    localparam int RES_WIDTH     = BASE_WIDTH + SCALER_WIDTH;
    localparam int RD_DATA_WIDTH = ID_WIDTH + RES_WIDTH;

    typedef logic [SCALER_WIDTH-1:0] scaler_t;
    typedef logic [ID_WIDTH-1:0]     id_t;
    typedef logic [BASE_WIDTH-1:0]   base_t;
    typedef logic [RES_WIDTH-1:0]    res_t;

    typedef struct packed {
        id_t  id;
        res_t res;
    } rd_word_t;

endpackage

// File: rtl/amplifier_if.sv
// rtl/amplifier_if.sv - host write port and result port of the amplifier
interface amplifier_if;
    import amplifier_pkg::*;

    logic                     wr_en_i;
    logic                     set_scaler_i;
    logic [WR_DATA_WIDTH-1:0] wr_data_i;
    logic                     rd_val_o;
    logic [RD_DATA_WIDTH-1:0] rd_data_o;
    scaler_t                  scaler_o;

    modport master (
        output wr_en_i, set_scaler_i, wr_data_i,
        input  rd_val_o, rd_data_o, scaler_o
    );

    modport slave (
        input  wr_en_i, set_scaler_i, wr_data_i,
        output rd_val_o, rd_data_o, scaler_o
    );

endinterface

// File: rtl/amp_mult.sv
// rtl/amp_mult.sv - combinational unsigned full-precision base x scaler product
module amp_mult
    import amplifier_pkg::*;
(
    input  base_t   base,
    input  scaler_t scaler,
    output res_t    res
);

    // Both operands widened to the result width so no product bits are lost.
    assign res = res_t'(base) * res_t'(scaler);

endmodule

// File: rtl/amplifier.sv
// rtl/amplifier.sv - programmable-gain multiplier; AMP_OUT_PIPE_EN adds a second output register stage
module amplifier
    import amplifier_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    amplifier_if.slave  bus
);

    scaler_t  scaler_q;
    res_t     product;
    rd_word_t s1_data_q;
    logic     s1_val_q;
    logic     sample;
    logic     load;
    id_t      sample_id;
    base_t    sample_base;

    assign sample      = bus.wr_en_i & ~bus.set_scaler_i;
    assign load        = bus.wr_en_i &  bus.set_scaler_i;
    assign sample_id   = bus.wr_data_i[WR_DATA_WIDTH-1 -: ID_WIDTH];
    assign sample_base = bus.wr_data_i[BASE_WIDTH-1:0];

    amp_mult u_mult (
        .base   (sample_base),
        .scaler (scaler_q),
        .res    (product)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scaler_q <= scaler_t'(1);
        end else if (load) begin
            scaler_q <= bus.wr_data_i[SCALER_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_val_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_val_q <= sample;
            if (sample) begin
                s1_data_q <= '{id: sample_id, res: product};
            end
        end
    end

`ifdef AMP_OUT_PIPE_EN
    rd_word_t s2_data_q;
    logic     s2_val_q;

    // Second stage only captures real results so rd_data_o still holds across idle cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_val_q  <= 1'b0;
            s2_data_q <= '0;
        end else begin
            s2_val_q <= s1_val_q;
            if (s1_val_q) begin
                s2_data_q <= s1_data_q;
            end
        end
    end

    assign bus.rd_val_o  = s2_val_q;
    assign bus.rd_data_o = s2_data_q;
`else
    assign bus.rd_val_o  = s1_val_q;
    assign bus.rd_data_o = s1_data_q;
`endif

    assign bus.scaler_o = scaler_q;

endmodule

// File: tb/tb_amplifier.sv
// tb/tb_amplifier.sv - randomized and directed self-checking bench for amplifier
module tb_amplifier;

`ifdef AMP_OUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    amplifier_if bus ();

    amplifier dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          v;
        logic [31:0] d;
    } ev_t;

    ev_t         q[$];
    ev_t         ev;
    logic [15:0] m_scaler;
    logic [31:0] m_held;
    bit          m_val;
    bit          m_en, m_set;
    logic [15:0] m_wd;

    // Reference: each edge produces an event; the output visible LAT edges later is that event.
    always @(posedge clk_i) begin
        m_en  = bus.wr_en_i;
        m_set = bus.set_scaler_i;
        m_wd  = bus.wr_data_i;
        if (rst_i) begin
            q.delete();
            m_held   = 32'h0;
            m_scaler = 16'd1;
            m_val    = 1'b0;
        end else begin
            ev.v = m_en && !m_set;
            ev.d = {m_wd[15:8], 24'(m_wd[7:0]) * 24'(m_scaler)};
            if (m_en && m_set) m_scaler = m_wd;
            q.push_back(ev);
            if (q.size() > LAT) void'(q.pop_front());
            if (q.size() == LAT) begin
                m_val = q[0].v;
                if (q[0].v) m_held = q[0].d;
            end else begin
                m_val = 1'b0;
            end
        end
        #1;
        chk("cmp_rd_val", 32'(bus.rd_val_o), 32'(m_val));
        chk("cmp_rd_data", bus.rd_data_o, m_held);
        chk("cmp_scaler", 32'(bus.scaler_o), 32'(m_scaler));
    end

    task automatic drive(input bit en, input bit set, input logic [15:0] d);
        bus.wr_en_i      = en;
        bus.set_scaler_i = set;
        bus.wr_data_i    = d;
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0);
    endtask

    task automatic sample_check(input string name, input logic [7:0] id, input logic [7:0] base,
                                input logic [31:0] exp);
        drive(1'b1, 1'b0, {id, base});
        repeat (LAT - 1) idle();
        chk({name, "_val"}, 32'(bus.rd_val_o), 32'd1);
        chk({name, "_data"}, bus.rd_data_o, exp);
    endtask

    task automatic reset_pulse();
        bus.wr_en_i      = 1'b0;
        bus.set_scaler_i = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        chk("rst_async_val", 32'(bus.rd_val_o), 32'd0);
        chk("rst_async_data", bus.rd_data_o, 32'h0);
        chk("rst_async_scaler", 32'(bus.scaler_o), 32'd1);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
    endtask

    logic [31:0] exp_b2b [3];

    initial begin
        bus.wr_en_i      = 1'b0;
        bus.set_scaler_i = 1'b0;
        bus.wr_data_i    = 16'h0;
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;
        idle();
        chk("reset_scaler", 32'(bus.scaler_o), 32'd1);
        chk("reset_val", 32'(bus.rd_val_o), 32'd0);
        chk("reset_data", bus.rd_data_o, 32'h0);

        sample_check("unity", 8'd5, 8'd25, 32'h0500_0019);

        drive(1'b1, 1'b1, 16'd100);
        chk("load100_scaler", 32'(bus.scaler_o), 32'd100);
        sample_check("gain100", 8'd5, 8'd25, 32'h0500_09C4);
        idle();
        chk("gain100_idle_val", 32'(bus.rd_val_o), 32'd0);
        chk("gain100_idle_hold", bus.rd_data_o, 32'h0500_09C4);

        drive(1'b1, 1'b1, 16'hFFFF);
        sample_check("max", 8'hAA, 8'd255, 32'hAAFE_FF01);

        drive(1'b1, 1'b1, 16'd7);
        exp_b2b[0] = 32'h0100_000E;
        exp_b2b[1] = 32'h0200_0015;
        exp_b2b[2] = 32'h0300_001C;
        for (int i = 0; i < 3 + LAT - 1; i++) begin
            if (i < 3) drive(1'b1, 1'b0, {8'(i + 1), 8'(i + 2)});
            else       idle();
            if (i >= LAT - 1) begin
                chk("b2b_val", 32'(bus.rd_val_o), 32'd1);
                chk("b2b_data", bus.rd_data_o, exp_b2b[i - LAT + 1]);
            end
        end

        drive(1'b1, 1'b1, 16'd42);
        repeat (LAT) idle();
        chk("load42_val", 32'(bus.rd_val_o), 32'd0);
        chk("load42_scaler", 32'(bus.scaler_o), 32'd42);
        drive(1'b0, 1'b1, 16'd9);
        chk("noen_scaler", 32'(bus.scaler_o), 32'd42);

        drive(1'b1, 1'b1, 16'd0);
        sample_check("zero_gain", 8'h3C, 8'd200, 32'h3C00_0000);

        drive(1'b1, 1'b1, 16'd3);
        drive(1'b1, 1'b0, {8'd9, 8'd11});
        reset_pulse();
        for (int i = 0; i < LAT + 1; i++) begin
            idle();
            chk("post_rst_val", 32'(bus.rd_val_o), 32'd0);
            chk("post_rst_data", bus.rd_data_o, 32'h0);
        end

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse();
            end else begin
                logic [15:0] d;
                bit en, set;
                en  = $urandom_range(0, 3) != 0;
                set = $urandom_range(0, 4) == 0;
                d   = 16'($urandom);
                if (set && $urandom_range(0, 7) == 0) d = 16'h0;
                drive(en, set, d);
            end
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
